// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands and decoded fields, inserts load-use bubbles, handles flush/stall.
// Latency 1 cycle; ex_stall freezes all ex_* state and raises id_hold; flush overrides stall. Optional WB_BYPASS_EN.
module id_ex_stage #(
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] NOP_CTRL = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_rd,
  input  logic [31:0]       d1_temp,
  input  logic [31:0]       d2_temp,
  input  logic [31:0]       wb_din,
  input  logic [4:0]        wb_rd,
  input  logic              wb_reg_wrt,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              id_hold,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_rs1_data,
  output logic [31:0]       ex_rs2_data,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_rd
);

  logic        load_use;
  logic [31:0] rs1_op;
  logic [31:0] rs2_op;

  assign load_use = ex_valid & ex_mem_rd & (ex_rd != 5'd0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // Gated with rst so a stall request cannot leak out while the stage is held in reset.
  assign id_hold = rst & (load_use | ex_stall) & ~flush;

`ifdef WB_BYPASS_EN
  // The register file only reflects this cycle's write after the edge, so forward it here.
  always_comb begin
    rs1_op = d1_temp;
    rs2_op = d2_temp;
    if (wb_reg_wrt && (wb_rd == id_rs1)) rs1_op = wb_din;
    if (wb_reg_wrt && (wb_rd == id_rs2)) rs2_op = wb_din;
    if (id_rs1 == 5'd0) rs1_op = 32'd0;
    if (id_rs2 == 5'd0) rs2_op = 32'd0;
  end
`else
  always_comb begin
    rs1_op = (id_rs1 == 5'd0) ? 32'd0 : d1_temp;
    rs2_op = (id_rs2 == 5'd0) ? 32'd0 : d2_temp;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= 32'd0;
      ex_imm      <= 32'd0;
      ex_rs1_data <= 32'd0;
      ex_rs2_data <= 32'd0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_ctrl     <= NOP_CTRL;
      ex_mem_rd   <= 1'b0;
    end else if (flush || (!ex_stall && load_use)) begin
      ex_valid    <= 1'b0;
      ex_pc       <= 32'd0;
      ex_imm      <= 32'd0;
      ex_rs1_data <= 32'd0;
      ex_rs2_data <= 32'd0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_ctrl     <= NOP_CTRL;
      ex_mem_rd   <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_imm      <= id_imm;
      ex_rs1_data <= rs1_op;
      ex_rs2_data <= rs2_op;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_ctrl     <= id_ctrl;
      ex_mem_rd   <= id_mem_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: table of per-cycle stimulus/expectations plus reset sequences.
module tb_id_ex_stage;

  localparam int CTRL_W = 16;
`ifdef WB_BYPASS_EN
  localparam logic [31:0] BYP1 = 32'h0000_CAFE;
  localparam logic [31:0] BYP2 = 32'h0000_F00D;
`else
  localparam logic [31:0] BYP1 = 32'h0000_0000;
  localparam logic [31:0] BYP2 = 32'h0000_0001;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [31:0]       id_pc, id_imm, d1_temp, d2_temp, wb_din;
  logic [4:0]        id_rs1, id_rs2, id_rd, wb_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_mem_rd, wb_reg_wrt, flush, ex_stall;
  logic              id_hold, ex_valid, ex_mem_rd;
  logic [31:0]       ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CTRL_W), .NOP_CTRL(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_ctrl(id_ctrl), .id_mem_rd(id_mem_rd),
    .d1_temp(d1_temp), .d2_temp(d2_temp),
    .wb_din(wb_din), .wb_rd(wb_rd), .wb_reg_wrt(wb_reg_wrt),
    .flush(flush), .ex_stall(ex_stall), .id_hold(id_hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_mem_rd(ex_mem_rd)
  );

  typedef struct {
    logic        valid; logic [31:0] pc; logic [31:0] imm;
    logic [4:0]  rs1;   logic [4:0]  rs2; logic [4:0] rd;
    logic [15:0] ctrl;  logic mem_rd;
    logic [31:0] d1;    logic [31:0] d2;
    logic [31:0] wdin;  logic [4:0]  wrd; logic wwrt;
    logic        fl;    logic st;
    // expectations: id_hold before the edge, ex_* after it
    logic        e_hold; logic e_valid; logic [31:0] e_pc; logic [31:0] e_imm;
    logic [31:0] e_r1d;  logic [31:0] e_r2d;
    logic [4:0]  e_rs1;  logic [4:0] e_rs2; logic [4:0] e_rd;
    logic [15:0] e_ctrl; logic e_mem_rd;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_pc = v.pc; id_imm = v.imm;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_ctrl = v.ctrl; id_mem_rd = v.mem_rd;
    d1_temp = v.d1; d2_temp = v.d2;
    wb_din = v.wdin; wb_rd = v.wrd; wb_reg_wrt = v.wwrt;
    flush = v.fl; ex_stall = v.st;
  endtask

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, ".ex_valid"},    {31'd0, ex_valid},  {31'd0, v.e_valid});
    chk({tag, ".ex_pc"},       ex_pc,              v.e_pc);
    chk({tag, ".ex_imm"},      ex_imm,             v.e_imm);
    chk({tag, ".ex_rs1_data"}, ex_rs1_data,        v.e_r1d);
    chk({tag, ".ex_rs2_data"}, ex_rs2_data,        v.e_r2d);
    chk({tag, ".ex_rs1"},      {27'd0, ex_rs1},    {27'd0, v.e_rs1});
    chk({tag, ".ex_rs2"},      {27'd0, ex_rs2},    {27'd0, v.e_rs2});
    chk({tag, ".ex_rd"},       {27'd0, ex_rd},     {27'd0, v.e_rd});
    chk({tag, ".ex_ctrl"},     {16'd0, ex_ctrl},   {16'd0, v.e_ctrl});
    chk({tag, ".ex_mem_rd"},   {31'd0, ex_mem_rd}, {31'd0, v.e_mem_rd});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".id_hold"},  {31'd0, id_hold},   32'd0);
    chk({tag, ".ex_valid"}, {31'd0, ex_valid},  32'd0);
    chk({tag, ".ex_pc"},    ex_pc,              32'd0);
    chk({tag, ".ex_rs1_data"}, ex_rs1_data,     32'd0);
    chk({tag, ".ex_rd"},    {27'd0, ex_rd},     32'd0);
    chk({tag, ".ex_ctrl"},  {16'd0, ex_ctrl},   32'd0);
    chk({tag, ".ex_mem_rd"},{31'd0, ex_mem_rd}, 32'd0);
  endtask

  initial begin
    string tag;
    vec_t  v;
    // inputs: valid pc imm rs1 rs2 rd ctrl mem_rd d1 d2 wdin wrd wwrt flush stall
    // expect: hold valid pc imm r1d r2d rs1 rs2 rd ctrl mem_rd
    vecs[0]  = '{1, 32'h40, 32'h100, 3, 4, 6, 16'h0011, 0, 32'h1234, 32'h5678, 0, 0, 0, 0, 0,
                 0, 1, 32'h40, 32'h100, 32'h1234, 32'h5678, 3, 4, 6, 16'h0011, 0};
    vecs[1]  = '{1, 32'h44, 32'h101, 1, 2, 5, 16'h0022, 1, 32'hA, 32'hB, 0, 0, 0, 0, 0,
                 0, 1, 32'h44, 32'h101, 32'hA, 32'hB, 1, 2, 5, 16'h0022, 1};
    // load-use on rs2: one bubble, then the held instruction loads
    vecs[2]  = '{1, 32'h48, 32'h102, 9, 5, 8, 16'h0033, 0, 32'hC, 32'hD, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0};
    vecs[3]  = '{1, 32'h48, 32'h102, 9, 5, 8, 16'h0033, 0, 32'hC, 32'hD, 0, 0, 0, 0, 0,
                 0, 1, 32'h48, 32'h102, 32'hC, 32'hD, 9, 5, 8, 16'h0033, 0};
    // three stalled cycles leave EX untouched
    for (int i = 4; i < 7; i++)
      vecs[i] = '{1, 32'h4C, 32'h103, 1, 2, 3, 16'h0044, 0, 32'h1, 32'h2, 0, 0, 0, 0, 1,
                  1, 1, 32'h48, 32'h102, 32'hC, 32'hD, 9, 5, 8, 16'h0033, 0};
    vecs[7]  = '{1, 32'h4C, 32'h103, 1, 2, 3, 16'h0044, 0, 32'h1, 32'h2, 0, 0, 0, 1, 1,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0};
    // x0: load to x0, then a reader of x0 with all-ones register data
    vecs[8]  = '{1, 32'h50, 32'h104, 0, 0, 0, 16'h0055, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,
                 0, 1, 32'h50, 32'h104, 0, 0, 0, 0, 0, 16'h0055, 1};
    vecs[9]  = '{1, 32'h54, 32'h105, 0, 0, 1, 16'h0066, 0, 32'hFFFF_FFFF, 32'h77, 0, 0, 0, 0, 0,
                 0, 1, 32'h54, 32'h105, 0, 0, 0, 0, 1, 16'h0066, 0};
    vecs[10] = '{1, 32'h58, 32'h106, 7, 3, 2, 16'h0077, 0, 32'h0, 32'h99, 32'hCAFE, 7, 1, 0, 0,
                 0, 1, 32'h58, 32'h106, BYP1, 32'h99, 7, 3, 2, 16'h0077, 0};
    vecs[11] = '{1, 32'h5C, 32'h107, 0, 7, 2, 16'h0078, 0, 32'h5, 32'h6, 32'hBEEF, 0, 1, 0, 0,
                 0, 1, 32'h5C, 32'h107, 0, 32'h6, 0, 7, 2, 16'h0078, 0};
    vecs[12] = '{1, 32'h60, 32'h108, 3, 7, 2, 16'h0079, 0, 32'h3, 32'h1, 32'hF00D, 7, 1, 0, 0,
                 0, 1, 32'h60, 32'h108, 32'h3, BYP2, 3, 7, 2, 16'h0079, 0};
    vecs[13] = '{1, 32'h64, 32'h109, 1, 1, 1, 16'h007A, 0, 32'h1, 32'h1, 0, 0, 0, 1, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0};
    // invalid load in EX must not cause a hazard
    vecs[14] = '{0, 32'h68, 32'h10A, 1, 2, 4, 16'h0088, 1, 32'h1, 32'h2, 0, 0, 0, 0, 0,
                 0, 0, 32'h68, 32'h10A, 32'h1, 32'h2, 1, 2, 4, 16'h0088, 1};
    vecs[15] = '{1, 32'h6C, 32'h10B, 4, 0, 0, 16'h0000, 0, 32'h44, 32'h0, 0, 0, 0, 0, 0,
                 0, 1, 32'h6C, 32'h10B, 32'h44, 0, 4, 0, 0, 16'h0000, 0};
    // load-use on rs1
    vecs[16] = '{1, 32'h70, 32'h10C, 1, 2, 9, 16'h0090, 1, 32'h1, 32'h2, 0, 0, 0, 0, 0,
                 0, 1, 32'h70, 32'h10C, 32'h1, 32'h2, 1, 2, 9, 16'h0090, 1};
    vecs[17] = '{1, 32'h74, 32'h10D, 9, 0, 3, 16'h0091, 0, 32'h99, 32'h0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0};
    vecs[18] = '{1, 32'h74, 32'h10D, 9, 0, 3, 16'h0091, 0, 32'h99, 32'h0, 0, 0, 0, 0, 0,
                 0, 1, 32'h74, 32'h10D, 32'h99, 32'h0, 9, 0, 3, 16'h0091, 0};

    rst = 1'b0;
    v = vecs[0];
    v.st = 1'b1;
    drive(v);
    #3;
    chk_reset_state("por");
    rst = 1'b1;
    ex_stall = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      tag = $sformatf("v%0d", i);
      drive(vecs[i]);
      #1;
      chk({tag, ".id_hold"}, {31'd0, id_hold}, {31'd0, vecs[i].e_hold});
      @(posedge clk);
      #1;
      chk_out(tag, vecs[i]);
    end

    // asynchronous reset mid-stream while a stall is requested
    v = vecs[0];
    v.pc = 32'h100;
    drive(v);
    @(posedge clk);
    #1;
    chk("rst.pre_pc", ex_pc, 32'h100);
    chk("rst.pre_valid", {31'd0, ex_valid}, 32'd1);
    ex_stall = 1'b1;
    #1;
    chk("rst.pre_hold", {31'd0, id_hold}, 32'd1);
    rst = 1'b0;
    #1;
    chk_reset_state("rst.async");
    @(posedge clk);
    #1;
    chk_reset_state("rst.held");
    rst = 1'b1;
    ex_stall = 1'b0;
    v.pc = 32'h104;
    drive(v);
    @(posedge clk);
    #1;
    chk("rst.post_pc", ex_pc, 32'h104);
    chk("rst.post_valid", {31'd0, ex_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register directly downstream of the register file.
- Captures the two register-file read operands together with the decoded ID-stage fields, and presents them registered to EX.
- Detects load-use hazards and inserts bubbles.
- Handles flush and downstream stall.
- Optionally bypasses the same-cycle write-back value, which the register file does not yet reflect.

Parameters:
CTRL_W, 16, width of the opaque decoded control bundle passed ID->EX
NOP_CTRL, 16'h0000, control value loaded on a bubble, flush or reset

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  32  PC of ID instruction
id_imm  in  32  decoded immediate
id_rs1  in  5  source register 1 index (also drives register-file rs1)
id_rs2  in  5  source register 2 index
id_rd  in  5  destination register index
id_ctrl  in  CTRL_W  decoded control bundle
id_mem_rd  in  1  ID instruction is a load
d1_temp  in  32  register-file read data for id_rs1
d2_temp  in  32  register-file read data for id_rs2
wb_din  in  32  write-back data (same net as register-file din)
wb_rd  in  5  write-back destination
wb_reg_wrt  in  1  write-back enable
flush  in  1  kill ID instruction (branch/jump taken in EX)
ex_stall  in  1  EX/MEM cannot accept; hold this register
id_hold  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc  out  32  registered id_pc
ex_imm  out  32  registered id_imm
ex_rs1_data  out  32  registered operand 1
ex_rs2_data  out  32  registered operand 2
ex_rs1  out  5  registered id_rs1 (for EX forwarding unit)
ex_rs2  out  5  registered id_rs2
ex_rd  out  5  registered id_rd
ex_ctrl  out  CTRL_W  registered id_ctrl
ex_mem_rd  out  1  registered id_mem_rd

Behaviour:
- Reset (rst=0, asynchronous): all ex_* outputs = 0, except ex_ctrl = NOP_CTRL. Valid mid-operation; no partial update survives. id_hold during reset = 0.
- load_use (combinational) = ex_valid & ex_mem_rd & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- id_hold = (load_use | ex_stall) & ~flush. It is combinational, with no registered latency.
- Per-edge update priority, highest first:
  1. flush → bubble.
  2. ex_stall → all ex_* hold their values.
  3. load_use → bubble.
  4. Otherwise load the ID fields. ex_valid = id_valid.
- Bubble definition:
  - ex_valid = 0, ex_ctrl = NOP_CTRL, ex_mem_rd = 0, ex_rd = 0.
  - Other fields: don't care. The implementation zeroes them.
- Load-use timing: exactly one bubble cycle. The next cycle EX holds the bubble, so load_use drops and the held ID instruction loads.
- Register index 0: operand always 0 regardless of d1_temp/d2_temp or bypass. x0 never triggers load_use.
- Latency: one cycle, ID fields → ex_* outputs.
- Simultaneous flush and ex_stall: flush wins. The EX instruction is replaced by a bubble.

Optional Feature:
Macro: WB_BYPASS_EN.
- Defined: on load, the operand for rs1 (and likewise rs2) = wb_din when wb_reg_wrt & (wb_rd == id_rs1) & (id_rs1 != 0); otherwise d1_temp/d2_temp.
- Not defined: operands = d1_temp/d2_temp unconditionally. The integrator must guarantee register-file write-before-read, e.g. an opposite-edge register-file clock.

Test Plan:
- Reset mid-stream: with ex_valid=1 and ex_pc=0x100, pulse rst low → ex_valid=0, ex_pc=0, ex_ctrl=NOP_CTRL immediately, without waiting for a clock edge.
- Normal flow: id_pc=0x40, id_rs1=3 with d1_temp=0x1234, id_valid=1 → next edge ex_pc=0x40, ex_rs1_data=0x1234, ex_valid=1.
- Load-use stall: EX holds a load with ex_rd=5; ID has id_rs2=5 → id_hold=1 and the next edge gives a bubble (ex_valid=0). The following edge loads the ID instruction, and id_hold=0.
- Flush vs stall: flush=1 and ex_stall=1 together → id_hold=0 and next edge ex_valid=0. With ex_stall=1 alone, ex_* are unchanged for 3 cycles.
- x0 handling: id_rs1=0 with d1_temp=0xFFFF_FFFF, and EX load with ex_rd=0 → ex_rs1_data=0 and no id_hold.
- Bypass (WB_BYPASS_EN defined): wb_reg_wrt=1, wb_rd=7, wb_din=0xCAFE, id_rs1=7, d1_temp=0x0 → ex_rs1_data=0xCAFE. Without the macro → ex_rs1_data=0x0.
